sha1_multiblock_engine: RTL

SHA1_MULTIBLOCK_ENGINE -- requirements
Module: sha1_multiblock_engine

---
 rtl/sha1_multiblock_engine.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/sha1_multiblock_engine.sv
// SHA-1 engine hashing a pre-padded multi-block message read from a dual-port
// BRAM. One round per clock, 16-word rolling message schedule, per-block
// latency READ_LAT+82 cycles (fetch READ_LAT+1, 80 rounds, 1 update).
module sha1_multiblock_engine #(
    parameter int ADDR_W     = 4,
    parameter int MAX_BLOCKS = 8,
    parameter int READ_LAT   = 2,
    localparam int CNT_W     = $clog2(MAX_BLOCKS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_blocks,
    input  logic              abort,
    input  logic [255:0]      q_a,
    input  logic [255:0]      q_b,
    output logic [ADDR_W-1:0] address_a,
    output logic [ADDR_W-1:0] address_b,
    output logic              wren_a,
    output logic              wren_b,
    output logic              busy,
    output logic [CNT_W-1:0]  blk_cnt,
    output logic [159:0]      digest,
    output logic              digest_valid,
    input  logic              digest_ready,
    output logic              h_done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, FETCH, ROUNDS, UPDATE, OUTPUT} state_t;

    state_t              state_q, state_d;
    logic [READ_LAT:0]   vld_pipe;
    logic [ADDR_W-1:0]   addr_a_q, addr_b_q;
    logic [CNT_W-1:0]    nblk_q, blk_cnt_q;
    logic [31:0]         h_q [5];
    logic [31:0]         a_q, b_q, c_q, d_q, e_q;
    logic [31:0]         w_q [16];
    logic [6:0]          round_q;
    logic                err_q;

    logic                start_ok, start_bad, abort_take, more, enter_fetch;
    logic [31:0]         f_val, k_val, t_sum, w_new;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    assign wren_a    = 1'b0;
    assign wren_b    = 1'b0;
    assign address_a = addr_a_q;
    assign address_b = addr_b_q;
    assign blk_cnt   = blk_cnt_q;
    assign err       = err_q;
    assign digest    = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};
    assign more      = (blk_cnt_q + CNT_W'(1)) < nblk_q;
    assign enter_fetch = start_ok || (state_q == UPDATE && more && !abort_take);

    // Next-state logic, status outputs and abort/accept arbitration
    always_comb begin
        state_d      = state_q;
        start_ok     = 1'b0;
        start_bad    = 1'b0;
        abort_take   = 1'b0;
        h_done       = 1'b0;
        busy         = (state_q != IDLE);
        digest_valid = (state_q == OUTPUT);
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_blocks != '0 && num_blocks <= CNT_W'(MAX_BLOCKS)) begin
                        start_ok = 1'b1;
                        state_d  = FETCH;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            FETCH:  if (vld_pipe[READ_LAT]) state_d = ROUNDS;
            ROUNDS: if (round_q == 7'd79) state_d = UPDATE;
            UPDATE: state_d = more ? FETCH : OUTPUT;
            OUTPUT: begin
                if (digest_ready) begin
                    h_done  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A consumer accepting the digest wins over a simultaneous abort
        if (state_q != IDLE && abort && !(state_q == OUTPUT && digest_ready)) begin
            abort_take = 1'b1;
            state_d    = IDLE;
        end
    end

    // Round function: f and K selected by round range, new schedule word
    always_comb begin
        f_val = 32'h0;
        k_val = 32'h0;
        if (round_q < 7'd20) begin
            f_val = (b_q & c_q) | (~b_q & d_q);
            k_val = 32'h5A827999;
        end else if (round_q < 7'd40) begin
            f_val = b_q ^ c_q ^ d_q;
            k_val = 32'h6ED9EBA1;
        end else if (round_q < 7'd60) begin
            f_val = (b_q & c_q) | (b_q & d_q) | (c_q & d_q);
            k_val = 32'h8F1BBCDC;
        end else begin
            f_val = b_q ^ c_q ^ d_q;
            k_val = 32'hCA62C1D6;
        end
        t_sum = rotl(a_q, 5) + f_val + e_q + k_val + w_q[0];
        // w_q[j] holds W[t+j], so W[t+16] draws from slots 13, 8, 2, 0
        w_new = rotl(w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0], 1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // BRAM read-latency tracker: a token walks READ_LAT+1 cycles through FETCH
    always_ff @(posedge clk) begin
        if (!rst_n || abort_take) vld_pipe <= '0;
        else                      vld_pipe <= {vld_pipe[READ_LAT-1:0], enter_fetch};
    end

    // Datapath: chaining value, working vars, schedule, counters, addresses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            nblk_q    <= '0;
            blk_cnt_q <= '0;
            round_q   <= '0;
            a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0; e_q <= '0;
            for (int i = 0; i < 5; i++)  h_q[i] <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            err_q <= start_bad;
            if (start_ok) begin
                addr_a_q  <= base_addr;
                addr_b_q  <= base_addr + ADDR_W'(1);
                nblk_q    <= num_blocks;
                blk_cnt_q <= '0;
                h_q[0] <= 32'h67452301;
                h_q[1] <= 32'hEFCDAB89;
                h_q[2] <= 32'h98BADCFE;
                h_q[3] <= 32'h10325476;
                h_q[4] <= 32'hC3D2E1F0;
            end
            if (!abort_take) begin
                case (state_q)
                    FETCH: begin
                        if (vld_pipe[READ_LAT]) begin
                            for (int i = 0; i < 8; i++) begin
                                w_q[i]     <= q_a[255-32*i -: 32];
                                w_q[8 + i] <= q_b[255-32*i -: 32];
                            end
                            a_q <= h_q[0]; b_q <= h_q[1]; c_q <= h_q[2];
                            d_q <= h_q[3]; e_q <= h_q[4];
                            round_q <= '0;
                        end
                    end
                    ROUNDS: begin
                        e_q <= d_q;
                        d_q <= c_q;
                        c_q <= rotl(b_q, 30);
                        b_q <= a_q;
                        a_q <= t_sum;
                        for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
                        w_q[15] <= w_new;
                        round_q <= round_q + 7'd1;
                    end
                    UPDATE: begin
                        h_q[0] <= h_q[0] + a_q;
                        h_q[1] <= h_q[1] + b_q;
                        h_q[2] <= h_q[2] + c_q;
                        h_q[3] <= h_q[3] + d_q;
                        h_q[4] <= h_q[4] + e_q;
                        blk_cnt_q <= blk_cnt_q + CNT_W'(1);
                        // Blocks occupy two consecutive words; wrap is intended
                        if (more) begin
                            addr_a_q <= addr_a_q + ADDR_W'(2);
                            addr_b_q <= addr_b_q + ADDR_W'(2);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
